// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: load and feed bundle between a matrix source, the feeder and a SIZE x SIZE systolic array.
// Ports (slave view, which the feeder uses):
//   in:  load_valid, load_sel, load_row, load_data, start
//   out: load_ready, busy, array_clear, feed_valid, out_west[SIZE], out_north[SIZE], feed_done
interface systolic_feeder_if #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8
);
  logic                      load_valid;
  logic                      load_ready;
  logic                      load_sel;
  logic [$clog2(SIZE)-1:0]   load_row;
  logic [SIZE*DATA_W-1:0]    load_data;
  logic                      start;
  logic                      busy;
  logic                      array_clear;
  logic                      feed_valid;
  logic [DATA_W-1:0]         out_west [SIZE];
  logic [DATA_W-1:0]         out_north [SIZE];
  logic                      feed_done;
  modport master (
    output load_valid, load_sel, load_row, load_data, start,
    input  load_ready, busy, array_clear, feed_valid, out_west, out_north, feed_done
  );
  modport slave (
    input  load_valid, load_sel, load_row, load_data, start,
    output load_ready, busy, array_clear, feed_valid, out_west, out_north, feed_done
  );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers matrices A and B, then streams them diagonally skewed into a systolic array.
// Ports: clk, rst (async, active-high), bus (systolic_feeder_if.slave: row loads, start,
//   busy/array_clear/feed_valid/feed_done status, out_west/out_north operand lanes).
// Option: define FEEDER_TRANSPOSE_B_EN to store B-bank loads column-major (load_row picks a column).
module systolic_feeder #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  systolic_feeder_if.slave bus
);
  localparam int RW = $clog2(SIZE);
  localparam int TW = $clog2(3*SIZE-2);
  localparam logic [TW-1:0] LAST = TW'(3*SIZE-3);
  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] t;
  logic [DATA_W-1:0] a [SIZE][SIZE];
  logic [DATA_W-1:0] b [SIZE][SIZE];
  logic [DATA_W-1:0] row [SIZE];
  logic [DATA_W-1:0] west_n [SIZE];
  logic [DATA_W-1:0] north_n [SIZE];
  int tn;
  always_comb begin
    state_n = state == IDLE  ? (bus.start ? CLEAR : IDLE) :
              state == CLEAR ? FEED :
              state == FEED  ? (t == LAST ? DONE : FEED) : IDLE;
  end
  // Outputs are registered, so lanes are computed for the feed step that the next edge presents.
  assign tn = state == CLEAR ? 0 : int'(t) + 1;
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    assign row[i]     = bus.load_data[i*DATA_W +: DATA_W];
    assign west_n[i]  = (state_n == FEED && tn >= i && tn < i + SIZE) ? a[i][RW'(tn - i)] : '0;
    assign north_n[i] = (state_n == FEED && tn >= i && tn < i + SIZE) ? b[RW'(tn - i)][i] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      t               <= '0;
      a               <= '{default: '0};
      b               <= '{default: '0};
      bus.load_ready  <= 1'b1;
      bus.busy        <= 1'b0;
      bus.array_clear <= 1'b0;
      bus.feed_valid  <= 1'b0;
      bus.feed_done   <= 1'b0;
      bus.out_west    <= '{default: '0};
      bus.out_north   <= '{default: '0};
    end else begin
      state           <= state_n;
      t               <= state == FEED ? t + 1'b1 : '0;
      bus.load_ready  <= state_n == IDLE;
      bus.busy        <= state_n != IDLE;
      bus.array_clear <= state_n == CLEAR;
      bus.feed_valid  <= state_n == FEED;
      bus.feed_done   <= state_n == DONE;
      bus.out_west    <= west_n;
      bus.out_north   <= north_n;
      if (bus.load_valid && bus.load_ready) begin
`ifdef FEEDER_TRANSPOSE_B_EN
        if (bus.load_sel)
          for (int k = 0; k < SIZE; k++) b[RW'(k)][bus.load_row] <= row[k];
        else
          a[bus.load_row] <= row;
`else
        if (bus.load_sel)
          b[bus.load_row] <= row;
        else
          a[bus.load_row] <= row;
`endif
      end
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table vectors, directed corner cases and random runs against a matrix-level model.
module tb_systolic_feeder;
  localparam int SIZE = 4;
  localparam int DW   = 8;
  localparam int RW   = $clog2(SIZE);
  localparam int LAST = 3*SIZE-3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  systolic_feeder_if #(.SIZE(SIZE), .DATA_W(DW)) bus ();
  systolic_feeder #(.SIZE(SIZE), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errs   = 0;
  int ma [SIZE][SIZE];
  int mb [SIZE][SIZE];
  int cap_w [LAST+1][SIZE];
  int cap_n [LAST+1][SIZE];
  typedef struct packed {
    logic [7:0]       t;
    logic [3:0][7:0]  w;
    logic [3:0][7:0]  n;
  } vec_t;
  vec_t tbl [7];
  function automatic vec_t mk(input int t, input int w0, w1, w2, w3, input int n0, n1, n2, n3);
    vec_t v;
    v.t = 8'(t);
    v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
    v.n[0] = 8'(n0); v.n[1] = 8'(n1); v.n[2] = 8'(n2); v.n[3] = 8'(n3);
    return v;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Expected west lane i at step t: row i of A, delayed by i steps.
  function automatic int ew(input int i, input int t);
    if (t - i >= 0 && t - i < SIZE) return ma[i][t-i];
    return 0;
  endfunction
  // Expected north lane j at step t: column j of B, delayed by j steps.
  function automatic int en(input int j, input int t);
    if (t - j >= 0 && t - j < SIZE) return mb[t-j][j];
    return 0;
  endfunction
  task automatic clear_model();
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = 0;
        mb[i][k] = 0;
      end
  endtask
  task automatic put(input bit sel, input int r, input int d [SIZE]);
    logic [SIZE*DW-1:0] pk;
    for (int k = 0; k < SIZE; k++) pk[k*DW +: DW] = DW'(d[k]);
    bus.load_valid = 1'b1;
    bus.load_sel   = sel;
    bus.load_row   = RW'(r);
    bus.load_data  = pk;
    for (int k = 0; k < SIZE; k++) begin
`ifdef FEEDER_TRANSPOSE_B_EN
      if (sel) mb[k][r] = d[k] & 255; else ma[r][k] = d[k] & 255;
`else
      if (sel) mb[r][k] = d[k] & 255; else ma[r][k] = d[k] & 255;
`endif
    end
  endtask
  task automatic load(input bit sel, input int r, input int d [SIZE]);
    put(sel, r, d);
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask
  // One full run; at step inj_t an illegal load of {9,9,9,9} into A row 0 and a start are attempted.
  task automatic run(input int inj_t);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.load_valid = 1'b0;
    chk("array_clear", int'(bus.array_clear), 1);
    chk("busy_in_clear", int'(bus.busy), 1);
    chk("valid_in_clear", int'(bus.feed_valid), 0);
    for (int t = 0; t <= LAST; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.load_valid = 1'b0;
      chk($sformatf("feed_valid t=%0d", t), int'(bus.feed_valid), 1);
      chk($sformatf("clear_low t=%0d", t), int'(bus.array_clear), 0);
      chk($sformatf("done_low t=%0d", t), int'(bus.feed_done), 0);
      for (int i = 0; i < SIZE; i++) begin
        cap_w[t][i] = int'(bus.out_west[i]);
        cap_n[t][i] = int'(bus.out_north[i]);
        chk($sformatf("west[%0d] t=%0d", i, t), cap_w[t][i], ew(i, t));
        chk($sformatf("north[%0d] t=%0d", i, t), cap_n[t][i], en(i, t));
      end
      if (t == inj_t) begin
        chk("load_ready_in_feed", int'(bus.load_ready), 0);
        bus.load_valid = 1'b1;
        bus.load_sel   = 1'b0;
        bus.load_row   = '0;
        bus.load_data  = {SIZE{8'd9}};
        bus.start      = 1'b1;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.load_valid = 1'b0;
    chk("feed_done", int'(bus.feed_done), 1);
    chk("valid_in_done", int'(bus.feed_valid), 0);
    chk("busy_in_done", int'(bus.busy), 1);
    chk("west0_in_done", int'(bus.out_west[0]), 0);
    @(negedge clk);
    chk("done_pulse_end", int'(bus.feed_done), 0);
    chk("busy_after_run", int'(bus.busy), 0);
    chk("ready_after_run", int'(bus.load_ready), 1);
  endtask
  initial begin
    int d [SIZE];
    // Step t, west lanes 0..3, north lanes 0..3 for A = B = 4i+k+1.
    tbl[0] = mk(0, 1, 0, 0, 0,    1, 0, 0, 0);
    tbl[1] = mk(1, 2, 5, 0, 0,    5, 2, 0, 0);
    tbl[2] = mk(2, 3, 6, 9, 0,    9, 6, 3, 0);
    tbl[3] = mk(3, 4, 7, 10, 13,  13, 10, 7, 4);
    tbl[4] = mk(6, 0, 0, 0, 16,   0, 0, 0, 16);
    tbl[5] = mk(7, 0, 0, 0, 0,    0, 0, 0, 0);
    tbl[6] = mk(9, 0, 0, 0, 0,    0, 0, 0, 0);
    bus.load_valid = 1'b0;
    bus.load_sel   = 1'b0;
    bus.load_row   = '0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    clear_model();
    // Reset
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.feed_valid), 0);
    chk("rst_clear", int'(bus.array_clear), 0);
    chk("rst_done", int'(bus.feed_done), 0);
    for (int i = 0; i < SIZE; i++) begin
      chk($sformatf("rst_west[%0d]", i), int'(bus.out_west[i]), 0);
      chk($sformatf("rst_north[%0d]", i), int'(bus.out_north[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(bus.load_ready), 1);
    // Skew with A = B = 4i+k+1
    for (int i = 0; i < SIZE; i++) begin
      for (int k = 0; k < SIZE; k++) d[k] = 4*i + k + 1;
      load(1'b0, i, d);
`ifdef FEEDER_TRANSPOSE_B_EN
      for (int k = 0; k < SIZE; k++) d[k] = 4*k + i + 1;
`endif
      load(1'b1, i, d);
    end
    run(-1);
    for (int e = 0; e < 7; e++)
      for (int i = 0; i < SIZE; i++) begin
        chk($sformatf("tbl west[%0d] t=%0d", i, tbl[e].t), cap_w[tbl[e].t][i], int'(tbl[e].w[i]));
        chk($sformatf("tbl north[%0d] t=%0d", i, tbl[e].t), cap_n[tbl[e].t][i], int'(tbl[e].n[i]));
      end
    // Load and start attempted during FEED are ignored
    run(1);
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_no_done", int'(bus.feed_done), 0);
    end
    run(-1);
    // Load together with start: the run sees the new row
    d = '{7, 0, 0, 0};
    put(1'b0, 0, d);
    run(-1);
    chk("simul_west0_t0", cap_w[0][0], 7);
    // Reset mid-run at t=4
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_valid", int'(bus.feed_valid), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_valid", int'(bus.feed_valid), 0);
    chk("midrst_ready", int'(bus.load_ready), 1);
    for (int i = 0; i < SIZE; i++) begin
      chk($sformatf("midrst_west[%0d]", i), int'(bus.out_west[i]), 0);
      chk($sformatf("midrst_north[%0d]", i), int'(bus.out_north[i]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    repeat (12) begin
      @(negedge clk);
      chk("no_done_after_rst", int'(bus.feed_done), 0);
    end
    run(-1);
    // B load through load_sel=1, row 0 = {1,2,3,4}
    d = '{1, 2, 3, 4};
    load(1'b1, 0, d);
    run(-1);
    chk("bsel north0 t0", cap_n[0][0], 1);
`ifdef FEEDER_TRANSPOSE_B_EN
    chk("transp north0 t1", cap_n[1][0], 2);
    chk("transp north1 t1", cap_n[1][1], 0);
`else
    chk("rowmaj north1 t1", cap_n[1][1], 2);
`endif
    // Random loads and runs
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int l = 0; l < n; l++) begin
        for (int k = 0; k < SIZE; k++) d[k] = $urandom_range(0, 255);
        load(1'($urandom_range(0, 1)), $urandom_range(0, SIZE-1), d);
      end
      run(($urandom_range(0, 1) == 1) ? $urandom_range(0, LAST) : -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Upstream stage of the SIZE x SIZE systolic array. It buffers operand matrices A and B, then streams them into the array's west and north edges with diagonal skew and zero padding. It also clears the array accumulators before each run and signals when the last operand has propagated through. This replaces hand-driven, unskewed in_west/in_north stimulus with a correctly timed operand stream.

Parameters:
SIZE, 4, array dimension; A, B and the array are SIZE x SIZE
DATA_W, 8, operand element width in bits

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
load_valid  input  1  load request for one matrix row
load_ready  output  1  feeder can accept a load; high only in IDLE
load_sel  input  1  0 = write A bank, 1 = write B bank
load_row  input  $clog2(SIZE)  row index written
load_data  input  SIZE*DATA_W  row elements; element k at bits [k*DATA_W +: DATA_W]
start  input  1  begin a feed run; sampled only in IDLE
busy  output  1  high in CLEAR, FEED and DONE
array_clear  output  1  one-cycle pulse to zero the array accumulators
feed_valid  output  1  high on every FEED cycle
out_west  output  DATA_W x SIZE (unpacked [SIZE])  row operands to array in_west
out_north  output  DATA_W x SIZE (unpacked [SIZE])  column operands to array in_north
feed_done  output  1  one-cycle pulse after the final FEED cycle

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; A and B banks cleared to 0.
  - All out_west/out_north = 0.
  - busy, array_clear, feed_valid, feed_done = 0; load_ready = 1 once in IDLE.
  - Reset mid-run aborts immediately; no feed_done is issued.
- Load handshake:
  - A row is written on a clk edge where load_valid && load_ready.
  - The bank is selected by load_sel; the row is indexed by load_row.
  - Loads are never accepted outside IDLE, and bank contents stay unchanged.
  - Rewriting a row overwrites it; there is no check that all rows were loaded.
- FSM:
  - IDLE -> CLEAR when start=1.
  - CLEAR: one cycle; array_clear=1, busy=1.
  - CLEAR -> FEED.
  - FEED: counter t runs 0..3*SIZE-3 (10 cycles at SIZE=4); feed_valid=1.
  - FEED -> DONE after t=3*SIZE-3.
  - DONE: one cycle; feed_done=1.
  - DONE -> IDLE.
- Timing:
  - start sampled at edge N -> CLEAR during cycle N+1 -> t=0 during cycle N+2.
  - All outputs are registered and change only on clk edges, except during async reset.
- Skew rule during FEED cycle t:
  - out_west[i] = A[i][t-i] if 0 <= t-i < SIZE, else 0.
  - out_north[j] = B[t-j][j] if 0 <= t-j < SIZE, else 0.
  - Cycles t = 2*SIZE-1 .. 3*SIZE-3 carry all zeros, so the last operands reach PE(SIZE-1,SIZE-1).
- Outside FEED, out_west and out_north = 0.
- Edge cases:
  - start while busy is ignored.
  - load_valid together with start in IDLE: the row is written and the run starts; that run uses the new row.
  - start held high through DONE starts a new run only after the return to IDLE (sampled in IDLE).
- Operands pass through unmodified; no arithmetic or width change.

Optional Feature:
FEEDER_TRANSPOSE_B_EN
- Defined: B-bank loads (load_sel=1) are stored transposed, so load_row selects a column of B and element k of load_data is B[k][load_row]. This lets column-major weights load directly.
- Undefined: B loads are row-major, identical to A.
- The skew rule is unchanged in both cases.

Test Plan:
1. Reset: assert rst for 2 cycles -> out_west = out_north = {0,0,0,0}; busy = feed_valid = array_clear = feed_done = 0; load_ready = 1 after release.
2. Skew: load A[i][k] = 4i+k+1 and B = A; pulse start.
   - Cycle after start: array_clear = 1.
   - Then 10 feed_valid cycles: t=0 west = {1,0,0,0}, north = {1,0,0,0}; t=1 west = {2,5,0,0}, north = {5,2,0,0}; t=3 west = {4,7,10,13}, north = {13,10,7,4}; t=6 west = {0,0,0,16}; t=7..9 all zeros.
   - feed_done pulses the following cycle; busy then drops.
3. Busy protection: during FEED, drive load_valid with row 0 = {9,9,9,9} and pulse start -> load_ready = 0, bank unchanged, only one run occurs, a single feed_done.
4. Simultaneous: in IDLE, write A row 0 = {7,0,0,0} with start=1 in the same cycle -> t=0 out_west[0] = 7.
5. Reset mid-run: assert rst at t=4 -> outputs 0 immediately, busy = 0, no feed_done; a rerun with no reload feeds all zeros.
6. FEEDER_TRANSPOSE_B_EN defined: load_sel=1, load_row=0, data = {1,2,3,4} -> t=0 north[0] = 1; t=1 north[0] = 2, north[1] = 0.
